// File: rtl/pic_pkg.sv
// Shared types and constants for the INTA cycle initiator.
// The state encoding and INTA polarity are common to the PIC-side logic.
package pic_pkg;

  localparam int VEC_W = 8;

  localparam logic INTA_ACTIVE = 1'b0;
  localparam logic INTA_IDLE   = 1'b1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PULSE1  = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_PULSE2  = 3'd3;
  localparam logic [2:0] S_STRETCH = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    PULSE1  = S_PULSE1,
    GAP     = S_GAP,
    PULSE2  = S_PULSE2,
    STRETCH = S_STRETCH,
    DONE    = S_DONE
  } state_t;

  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/inta_cycle_initiator_if.sv
// Handshake bundle between the CPU-side INTA initiator and the PIC.
// master is the initiator; slave is the PIC side.
interface inta_cycle_initiator_if;
  import pic_pkg::*;

  logic             INT;
  logic             int_enable;
  logic [VEC_W-1:0] DATA_IN;
  logic             IV_ready;
  logic             INTA;
  logic [VEC_W-1:0] vector;
  logic             vector_valid;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  INT, int_enable, DATA_IN, IV_ready,
    output INTA, vector, vector_valid, busy, timeout_err
  );

  modport slave (
    output INT, int_enable, DATA_IN, IV_ready,
    input  INTA, vector, vector_valid, busy, timeout_err
  );

endinterface

// File: rtl/inta_phase_timer.sv
// Loadable down-counter with zero flag; times pulse, gap and stretch phases.
module inta_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/inta_cycle_initiator.sv
// CPU-side 8259A interrupt-acknowledge initiator: two INTA pulses,
// vector capture on the second, with bounded stretch for a late PIC.
module inta_cycle_initiator
  import pic_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst,
  inta_cycle_initiator_if.master bus
);

  localparam int CW = cnt_width(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LD_P = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LD_G = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LD_T = CW'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic             inta_q;
  logic             valid_q;
  logic             busy_q;
  logic             terr_q;
  logic [VEC_W-1:0] vec_q;

  logic          start;
  logic          ld;
  logic          dec;
  logic          zero;
  logic [CW-1:0] ld_val;

  assign start = bus.INT && bus.int_enable;

  // Timer reloads on every state entry, so it never needs to wrap.
  always_comb begin
    ld     = 1'b0;
    dec    = 1'b0;
    ld_val = LD_P;
    unique case (state_q)
      IDLE: ld = start;
      PULSE1: begin
        ld     = zero;
        ld_val = LD_G;
        dec    = !zero;
      end
      GAP: begin
        ld  = zero;
        dec = !zero;
      end
      PULSE2: begin
        ld     = zero && !bus.IV_ready;
        ld_val = LD_T;
        dec    = !zero;
      end
      STRETCH: dec = !zero;
      default: ;
    endcase
  end

  inta_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .load_val_i (ld_val),
    .dec_i      (dec),
    .zero_o     (zero)
  );

  // INT/int_enable are only looked at in IDLE: a started sequence
  // always issues both pulses so the PIC edge count stays aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      inta_q  <= INTA_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= PULSE1;
            inta_q  <= INTA_ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        PULSE1: begin
          if (zero) begin
            state_q <= GAP;
            inta_q  <= INTA_IDLE;
          end
        end
        GAP: begin
          if (zero) begin
            state_q <= PULSE2;
            inta_q  <= INTA_ACTIVE;
          end
        end
        PULSE2: begin
          if (zero) begin
            if (bus.IV_ready) begin
              state_q <= DONE;
              inta_q  <= INTA_IDLE;
              vec_q   <= bus.DATA_IN;
              valid_q <= 1'b1;
              terr_q  <= 1'b0;
            end else begin
              state_q <= STRETCH;
            end
          end
        end
        STRETCH: begin
          if (bus.IV_ready) begin
            state_q <= DONE;
            inta_q  <= INTA_IDLE;
            vec_q   <= bus.DATA_IN;
            valid_q <= 1'b1;
            terr_q  <= 1'b0;
          end else if (zero) begin
            state_q <= DONE;
            inta_q  <= INTA_IDLE;
            terr_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.INTA         = inta_q;
  assign bus.vector       = vec_q;
  assign bus.vector_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = terr_q;

endmodule
